h264_xform_arbiter: RTL
=======================

# h264_xform_arbiter

Arbiter and sequencer that shares the single forward core-transform/quantise pipeline between the intra4x4 luma requester and the intra8x8 chroma requester. Grants the transform for one 4x4 block at a time, forwards exactly four residual words, and holds ownership until the reconstruction feedback strobe for that block returns. It then routes the strobe back to the owning requester and re-arbitrates. Sits between the two intra prediction controllers and the transform input.

## Interface
- WIDTH, default 36: residual word width (4 x 9-bit residuals per word).
- BLK_WORDS, default 4: words per 4x4 block; must be a power of two, 2..8.
- CLK2  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- LUMA_REQ / CHROMA_REQ  in  1  requester wants the transform for one block.
- LUMA_VALID / CHROMA_VALID  in  1  requester data word valid.
- LUMA_DATA / CHROMA_DATA  in  WIDTH  residual word.
- LUMA_GNT / CHROMA_GNT  out  1  ownership granted, registered.
- LUMA_READY / CHROMA_READY  out  1  word accepted this cycle (combinational: GNT & XFORM_READY & state STREAM).
- XFORM_READY  in  1  transform can take a word.
- XFORM_STROBE  out  1  registered word strobe to transform.
- XFORM_DATA  out  WIDTH  registered word to transform.
- XFORM_SRC  out  1  0 = luma, 1 = chroma; valid with XFORM_STROBE.
- FBSTROBE  in  1  reconstruction feedback for the in-flight block.
- LUMA_FB / CHROMA_FB  out  1  FBSTROBE routed to the owner (combinational).
- BUSY  out  1  state != IDLE.
- FB_ERR  out  1  sticky: FBSTROBE seen outside WAIT_FB.

## Operation
- States: IDLE, STREAM, WAIT_FB. Register `owner` (0 luma, 1 chroma), `last` (last served), word counter cnt (log2 BLK_WORDS bits).
- IDLE: if any REQ, pick winner, set owner, assert its GNT, go STREAM, cnt=0. No REQ: stay.
- Arbitration: see Configuration. Single request always wins.
- STREAM: accept = owner VALID & XFORM_READY. On accept: XFORM_DATA <= owner DATA, XFORM_SRC <= owner, XFORM_STROBE <= 1 next cycle, cnt++. Non-owner VALID/DATA ignored. On accept with cnt == BLK_WORDS-1: drop GNT, go WAIT_FB, last <= owner.
- WAIT_FB: on FBSTROBE, pulse owner's FB same cycle, go IDLE. No timeout.
- REQ deasserted mid-block: ignored; ownership held until all words and feedback complete.
- FBSTROBE in IDLE or STREAM: ignored for routing, FB_ERR set; cleared only by reset.
- Reset (any time, incl. mid-block): state IDLE, cnt 0, owner 0, last=1 (luma wins first tie), all outputs 0, FB_ERR 0. In-flight block abandoned.

## Timing
- REQ seen in IDLE at edge n: GNT high after edge n, STREAM from cycle n+1.
- Word accepted at edge k: XFORM_STROBE/DATA high for cycle after edge k; one cycle latency, back-to-back accepts give back-to-back strobes.
- Minimum block occupancy: 1 (grant) + BLK_WORDS + 1 (FBSTROBE earliest in the cycle after last accept) cycles; FBSTROBE on the same edge as last accept is treated as out-of-state (FB_ERR).
- After FB, one IDLE cycle before next GNT; GNT never high in WAIT_FB or IDLE.
- At most one GNT high at any time.

## Configuration
- XFORM_ARB_ROUNDROBIN_EN defined: tie (both REQ in IDLE) goes to requester != last; alternating service under continuous load.
- Undefined: fixed priority, luma always wins ties; `last` still tracked but unused for arbitration.

## Test plan
- Reset: RESET_N low mid-STREAM after 2 words -> next cycle all outputs 0, BUSY 0; release, LUMA_REQ -> LUMA_GNT one cycle later, cnt restarts at 0.
- Luma only, VALID every cycle, XFORM_READY=1, DATA 0x1..0x4 -> XFORM_STROBE 4 consecutive cycles, DATA 0x1..0x4, SRC 0; GNT drops; FBSTROBE -> LUMA_FB 1 cycle, BUSY 0 next cycle.
- XFORM_READY toggling 1,0,1,0 -> only 4 strobes total, DATA order preserved, no duplication.
- Both REQ held, 3 blocks, ROUNDROBIN_EN defined -> owners L,C,L; undefined -> L,L,L.
- CHROMA_REQ dropped after 1 word -> CHROMA_GNT held, remaining 3 words accepted when VALID, FB routed to CHROMA_FB.
- FBSTROBE while IDLE -> FB_ERR 1, no LUMA_FB/CHROMA_FB, stays 1 until reset.

Source files
------------

// File: rtl/h264_xform_arbiter.sv
// h264_xform_arbiter: shares one forward transform between the luma and chroma intra requesters.
// Optional macro XFORM_ARB_ROUNDROBIN_EN: ties go to the requester not served last;
// when undefined, luma wins every tie (fixed priority).
module h264_xform_arbiter #(
    parameter int WIDTH     = 36,
    parameter int BLK_WORDS = 4
) (
    input  logic             clk2_i,
    input  logic             reset_n_i,
    input  logic             luma_req_i,
    input  logic             chroma_req_i,
    input  logic             luma_valid_i,
    input  logic             chroma_valid_i,
    input  logic [WIDTH-1:0] luma_data_i,
    input  logic [WIDTH-1:0] chroma_data_i,
    output logic             luma_gnt_o,
    output logic             chroma_gnt_o,
    output logic             luma_ready_o,
    output logic             chroma_ready_o,
    input  logic             xform_ready_i,
    output logic             xform_strobe_o,
    output logic [WIDTH-1:0] xform_data_o,
    output logic             xform_src_o,
    input  logic             fbstrobe_i,
    output logic             luma_fb_o,
    output logic             chroma_fb_o,
    output logic             busy_o,
    output logic             fb_err_o
);
    localparam int CW = $clog2(BLK_WORDS);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_FB} state_e;

    state_e           state_q;
    logic             owner_q;
    logic             last_q;
    logic [CW-1:0]    cnt_q;
    logic             luma_gnt_q;
    logic             chroma_gnt_q;
    logic             strobe_q;
    logic             src_q;
    logic             fb_err_q;
    logic [WIDTH-1:0] data_q;
    logic             in_stream;
    logic             in_wait;
    logic             own_valid;
    logic [WIDTH-1:0] own_data;
    logic             accept;
    logic             tie_d;
    logic             winner_d;

    // Owner-side word selection, acceptance and the arbitration winner for the next grant
    always_comb begin
        in_stream = state_q == STREAM;
        in_wait   = state_q == WAIT_FB;
        own_valid = owner_q ? chroma_valid_i : luma_valid_i;
        own_data  = owner_q ? chroma_data_i : luma_data_i;
        accept    = in_stream & own_valid & xform_ready_i;
`ifdef XFORM_ARB_ROUNDROBIN_EN
        tie_d     = ~last_q;
`else
        tie_d     = 1'b0;
`endif
        winner_d  = (luma_req_i & chroma_req_i) ? tie_d : chroma_req_i;
    end

    // Block sequencer: grant, stream BLK_WORDS words, hold until feedback returns
    always_ff @(posedge clk2_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            luma_gnt_q   <= 1'b0;
            chroma_gnt_q <= 1'b0;
            strobe_q     <= 1'b0;
            src_q        <= 1'b0;
            data_q       <= '0;
            fb_err_q     <= 1'b0;
        end else begin
            strobe_q <= accept;
            if (accept) begin
                data_q <= own_data;
                src_q  <= owner_q;
            end
            if (fbstrobe_i && !in_wait) fb_err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (luma_req_i || chroma_req_i) begin
                        state_q      <= STREAM;
                        owner_q      <= winner_d;
                        luma_gnt_q   <= ~winner_d;
                        chroma_gnt_q <= winner_d;
                        cnt_q        <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(BLK_WORDS - 1)) begin
                            state_q      <= WAIT_FB;
                            luma_gnt_q   <= 1'b0;
                            chroma_gnt_q <= 1'b0;
                            last_q       <= owner_q;
                        end
                    end
                end
                WAIT_FB: begin
                    if (fbstrobe_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign luma_gnt_o     = luma_gnt_q;
    assign chroma_gnt_o   = chroma_gnt_q;
    assign luma_ready_o   = luma_gnt_q & xform_ready_i & in_stream;
    assign chroma_ready_o = chroma_gnt_q & xform_ready_i & in_stream;
    assign xform_strobe_o = strobe_q;
    assign xform_data_o   = data_q;
    assign xform_src_o    = src_q;
    assign luma_fb_o      = in_wait & fbstrobe_i & ~owner_q;
    assign chroma_fb_o    = in_wait & fbstrobe_i & owner_q;
    assign busy_o         = state_q != IDLE;
    assign fb_err_o       = fb_err_q;
endmodule
